// File: rtl/clock_pkg.sv
// Shared types and constants for the clock display path.
// Used by the BCD scheduler and the 7-segment display driver.
package clock_pkg;

  localparam int BCD_DIGITS = 4;
  localparam int BCD_W      = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  function automatic int digit_lsb(input int idx);
    return idx * BCD_W;
  endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// Double-dabble correction: add 3 to each BCD digit that is 5 or more,
// so the following left shift carries correctly into the next digit.
module bcd_dabble_step
  import clock_pkg::*;
(
  input  logic [BCD_DIGITS*BCD_W-1:0] bcd_in,
  output logic [BCD_DIGITS*BCD_W-1:0] bcd_out
);

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_dig
    localparam int LSB = digit_lsb(g);
    logic [BCD_W-1:0] d;
    assign d = bcd_in[LSB +: BCD_W];
    assign bcd_out[LSB +: BCD_W] =
      (d >= BCD_W'(5)) ? d + BCD_W'(3) : d;
  end

endmodule

// File: rtl/bcd_conv_sched.sv
// Round-robin scheduler sharing one iterative binary-to-BCD converter
// among the clock counters; one conversion per BIN_W+2 cycles.
module bcd_conv_sched
  import clock_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int BIN_W = 12
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*BIN_W-1:0]     bin_in,
  output logic [N_REQ-1:0]           ack,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(N_REQ)-1:0]   done_id,
  output logic [15:0]                bcd_out
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int ACC_W = BCD_DIGITS * BCD_W;
  localparam int CNT_W = $clog2(BIN_W);

  state_t             state;
  state_t             state_nx;
  logic               grant;
  logic               shift_en;
  logic               last_shift;
  logic               found;
  logic [ID_W-1:0]    last_id;
  logic [ID_W-1:0]    cur_id;
  logic [ID_W-1:0]    win;
  logic [ID_W:0]      base;
  logic [ID_W:0]      pick;
  logic [ID_W:0]      sum;
  logic [2*N_REQ-1:0] rot;
  logic [N_REQ-1:0]   ack_nx;
  logic [BIN_W-1:0]   opnd;
  logic [BIN_W-1:0]   bin_q;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_fix;
  logic [ACC_W-1:0]   acc_nx;
  logic [CNT_W-1:0]   cnt;

  // Round-robin pick: rotate so last_id+1 sits at bit 0, take lowest set bit.
  always_comb begin
    base  = {1'b0, last_id} + 1'b1;
    rot   = {req, req} >> base;
    found = 1'b0;
    pick  = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (rot[j]) begin
        found = 1'b1;
        pick  = (ID_W+1)'(j);
      end
    end
    sum = base + pick;
    if (sum >= (ID_W+1)'(N_REQ)) sum = sum - (ID_W+1)'(N_REQ);
    win    = sum[ID_W-1:0];
    opnd   = '0;
    ack_nx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win == ID_W'(i)) begin
        opnd      = bin_in[i*BIN_W +: BIN_W];
        ack_nx[i] = grant;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state and control strobes.
  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    shift_en = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (found) begin
          grant    = 1'b1;
          state_nx = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shift_en = 1'b1;
        if (last_shift) state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign last_shift = (cnt == CNT_W'(BIN_W - 1));

  bcd_dabble_step u_step (
    .bcd_in  (acc),
    .bcd_out (acc_fix)
  );

  assign acc_nx = ACC_W'({acc_fix, bin_q[BIN_W-1]});

  // Datapath: operand load on grant, shift-add-3, result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_id <= ID_W'(N_REQ - 1);
      cur_id  <= '0;
      bin_q   <= '0;
      acc     <= '0;
      cnt     <= '0;
      ack     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= '0;
      bcd_out <= '0;
    end else begin
      ack  <= ack_nx;
      done <= 1'b0;
      if (grant) begin
        bin_q   <= opnd;
        acc     <= '0;
        cnt     <= '0;
        cur_id  <= win;
        last_id <= win;
        busy    <= 1'b1;
      end
      if (shift_en) begin
        acc   <= acc_nx;
        bin_q <= bin_q << 1;
        cnt   <= cnt + 1'b1;
        if (last_shift) begin
          bcd_out <= acc_nx;
          done_id <= cur_id;
          done    <= 1'b1;
          busy    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Randomized and directed bench for bcd_conv_sched against a
// transaction-level reference model (decimal arithmetic, RR queue).
module tb_bcd_conv_sched;

  localparam int N = 4;
  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req;
  logic [N*W-1:0] bin_in;
  logic [N-1:0] ack;
  logic         busy;
  logic         done;
  logic [1:0]   done_id;
  logic [15:0]  bcd_out;

  bcd_conv_sched #(.N_REQ(N), .BIN_W(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .bin_in  (bin_in),
    .ack     (ack),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .bcd_out (bcd_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  bit [N-1:0] pend;
  int         val[N];
  int         m_phase, m_left, m_last, m_id, m_val;
  logic [N-1:0] e_ack;
  bit         e_busy, e_done;
  int         e_id, e_bcd;
  int         glog[$];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int to_bcd(int v);
    return (((v / 1000) % 10) << 12) | (((v / 100) % 10) << 8) |
           (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  function automatic void drive();
    req = pend;
    for (int i = 0; i < N; i++) bin_in[i*W +: W] = val[i][W-1:0];
  endfunction

  function automatic void mreset();
    m_phase = 0;
    m_left  = 0;
    m_last  = N - 1;
    e_ack   = '0;
    e_busy  = 0;
    e_done  = 0;
    e_id    = 0;
    e_bcd   = 0;
  endfunction

  task automatic step();
    logic [N-1:0] r;
    int vs[N];
    r = req;
    for (int i = 0; i < N; i++) vs[i] = val[i];
    @(posedge clk);
    #1;
    e_ack  = '0;
    e_done = 0;
    case (m_phase)
      0: begin
        if (r != 0) begin
          for (int o = 1; o <= N; o++) begin
            int c;
            c = (m_last + o) % N;
            if (r[c]) begin
              m_last   = c;
              m_id     = c;
              m_val    = vs[c];
              e_ack[c] = 1'b1;
              m_phase  = 1;
              m_left   = W;
              break;
            end
          end
        end
      end
      1: begin
        m_left--;
        if (m_left == 0) begin
          m_phase = 2;
          e_done  = 1;
          e_bcd   = to_bcd(m_val);
          e_id    = m_id;
        end
      end
      default: m_phase = 0;
    endcase
    e_busy = (m_phase == 1);
    chk("ack", ack, e_ack);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("done_id", done_id, e_id);
    chk("bcd_out", bcd_out, e_bcd);
    for (int i = 0; i < N; i++) if (ack[i]) glog.push_back(i);
    for (int i = 0; i < N; i++) if (e_ack[i]) pend[i] = 0;
    drive();
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic post(int i, int v);
    val[i]  = v;
    pend[i] = 1;
    drive();
  endtask

  task automatic reset_mid();
    #3 rst_n = 1'b0;
    #1;
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_id", done_id, 0);
    chk("rst_bcd", bcd_out, 0);
    mreset();
    pend = '0;
    drive();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int bvals[4] = '{0, 9, 10, 4095};
  int bexp[4]  = '{'h0, 'h9, 'h10, 'h4095};

  initial begin
    mreset();
    pend = '0;
    for (int i = 0; i < N; i++) val[i] = 0;
    drive();
    #12;
    chk("por_ack", ack, 0);
    chk("por_busy", busy, 0);
    chk("por_done", done, 0);
    chk("por_bcd", bcd_out, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    post(0, 1250);
    run(16);
    chk("single_bcd", bcd_out, 'h1250);
    chk("single_id", done_id, 0);

    for (int k = 0; k < 4; k++) begin
      post(k, bvals[k]);
      run(16);
      chk("bound_bcd", bcd_out, bexp[k]);
      chk("bound_id", done_id, k);
    end

    reset_mid();
    glog.delete();
    post(0, 59);
    post(1, 23);
    post(2, 7);
    post(3, 1000);
    run(4 * 14 + 4);
    chk("simul_n", glog.size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < glog.size()) chk("simul_order", glog[k], k);
    chk("simul_last", bcd_out, 'h1000);

    post(1, 77);
    run(16);
    glog.delete();
    post(0, 5);
    post(3, 6);
    run(32);
    chk("rr_n", glog.size(), 2);
    if (glog.size() >= 2) begin
      chk("rr_first", glog[0], 3);
      chk("rr_second", glog[1], 0);
    end

    post(2, 321);
    run(6);
    reset_mid();
    run(3);
    post(2, 4000);
    run(16);
    chk("rec_bcd", bcd_out, 'h4000);
    chk("rec_id", done_id, 2);

    post(1, 111);
    run(2);
    post(2, 222);
    post(3, 333);
    run(3);
    pend[2] = 0;
    drive();
    glog.delete();
    run(30);
    chk("wd_n", glog.size(), 1);
    if (glog.size() >= 1) chk("wd_grant", glog[0], 3);
    chk("wd_bcd", bcd_out, 'h333);

    post(1, 1234);
    run(1);
    val[1] = 999;
    drive();
    run(15);
    chk("opchg_bcd", bcd_out, 'h1234);

    for (int c = 0; c < 600; c++) begin
      int i;
      i = $urandom_range(0, N - 1);
      if (!pend[i] && $urandom_range(0, 3) == 0)
        post(i, $urandom_range(0, 4095));
      else if (pend[i] && $urandom_range(0, 19) == 0) begin
        pend[i] = 0;
        drive();
      end else if (!pend[i]) begin
        val[i] = $urandom_range(0, 4095);
        drive();
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_conv_sched.md
# bcd_conv_sched

Round-robin scheduler that shares one iterative binary-to-BCD converter among up to `N_REQ` requesters: seconds, minutes, hours and alarm counters of the digital clock. Each requester presents a 12-bit binary value with a level request. The block grants one requester at a time and runs a shift-add-3 (double-dabble) conversion over `BIN_W` cycles. It then returns four packed BCD digits tagged with the requester id. It sits between the time-keeping counters and the 7-segment display driver, replacing per-counter combinational divide/modulo converters.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `BIN_W`, 12, binary operand width; result is always 4 BCD digits
- `clk` in 1: system clock
- `rst_n` in 1: asynchronous, active-low reset
- `req` in N_REQ: level request per requester
- `bin_in` in N_REQ*BIN_W: operand of requester i at bits [i*BIN_W +: BIN_W]
- `ack` out N_REQ: one-cycle pulse to the granted requester; operand sampled at that edge
- `busy` out 1: high from grant until `done`
- `done` out 1: one-cycle pulse, result valid
- `done_id` out clog2(N_REQ): requester id of the result; held until the next `done`
- `bcd_out` out 16: {thousands, hundreds, tens, ones}; held until the next `done`

## Operation
- FSM states: IDLE, SHIFT, DONE.
- **IDLE**
  - If any `req` is high, select the winner by round-robin, searching from `last_id+1` upward with wrap.
  - Load `bin_in[winner]` into the shift register and clear the BCD accumulator and counter.
  - Pulse `ack[winner]`, set `last_id=winner`, go to SHIFT.
- **SHIFT**, each cycle:
  - Add 3 to every BCD digit ≥5.
  - Shift {bcd, bin} left by 1.
  - After the `BIN_W`-th shift, register the accumulator into `bcd_out`, the id into `done_id`, and go to DONE.
- **DONE**: `done=1` for exactly this cycle. Always go to IDLE next; no grant is made in DONE.
- **Requester handshake**
  - A requester keeps `req` high until it sees `ack`, and must deassert it in the cycle after `ack`.
  - `req` still high in IDLE counts as a new request.
  - Dropping `req` before `ack` withdraws the request with no side effects.
  - `bin_in` changes after `ack` do not affect the conversion in flight.
- **Arithmetic**
  - Accumulator is 16 bits.
  - Max operand 4095 gives 0x4095, so no overflow is possible.
  - Digits are never above 9 in `bcd_out`.
- **Reset** (asserted at any time, including mid-SHIFT)
  - State goes to IDLE; the in-flight conversion is discarded with no `done`.
  - `last_id = N_REQ-1`, so requester 0 has first priority.
  - `ack=0`, `busy=0`, `done=0`, `done_id=0`, `bcd_out=0`.

## Timing
- Request seen in IDLE at edge k gives `ack` and `busy` high in cycle k+1.
- Shifts occur at edges k+1 … k+BIN_W.
- `done`, `bcd_out` and `done_id` update at edge k+BIN_W; `done` is high for cycle k+BIN_W+1 (12 cycles after `ack` for BIN_W=12).
- `busy` falls together with `done` rising.
- Earliest next grant is at edge k+BIN_W+2, so back-to-back throughput is one conversion per BIN_W+2 = 14 cycles.
- Worst-case wait for a requester under full load: (N_REQ-1)*(BIN_W+2) cycles.
- All outputs are registered; no combinational path from `req` or `bin_in` to any output.

## Structure
- Package `clock_pkg` holds:
  - the FSM state enum
  - constants `BCD_DIGITS=4` and `BCD_W=4`
  - the digit-index helper for `bcd_out` slicing, shared with the display driver
- Sub-module `bcd_dabble_step`: combinational add-3-if-≥5 correction over four digits, instantiated once in the SHIFT datapath.
- Arbiter and counter stay inline.

## Test plan
- **Single request:** `req[0]`, value 1250 → `ack[0]` one cycle; `done` 12 cycles later; `bcd_out=0x1250`, `done_id=0`.
- **Boundaries:** 0 → 0x0000; 9 → 0x0009; 10 → 0x0010; 4095 → 0x4095.
- **Simultaneous requests:** all four requesters request together after reset with values 59, 23, 7, 1000 → grants in order 0, 1, 2, 3 at 14-cycle spacing, each with the matching result. Then after `last_id=1`, assert `req[0]` and `req[3]` together → 3 is granted before 0.
- **Reset mid-operation:** assert `rst_n` low during cycle 5 of SHIFT → no `done`, all outputs 0. The next request converts correctly.
- **Request withdrawn:** `req[2]` dropped while busy serving 1 → no `ack[2]`. After the conversion, the next grant goes to a still-pending requester.
- **Operand change after ack:** change `bin_in[1]` the cycle after `ack[1]` → the result reflects the value sampled at grant.
